// File: rtl/byte_lane_packer.sv
// Byte-to-halfword packer feeding a 16-bit byte-enabled register.
// Bytes arrive on a valid/ready handshake and are paired into 16-bit words,
// lane 0 first. A lone lane-0 byte is flushed on in_last or after an idle
// timeout, with byteena marking only the lanes that were actually written.
module byte_lane_packer #(
  parameter int unsigned FLUSH_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_d,
  output logic [1:0]  out_byteena
);

  // Idle counter only needs to reach FLUSH_TIMEOUT; keep at least one bit.
  localparam int unsigned   CntW   = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FLUSH_TIMEOUT);

  localparam logic [0:0] StEmpty = 1'b0;
  localparam logic [0:0] StHalf  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [7:0]      hold_q, hold_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [15:0]     data_q, data_d;
  logic [1:0]      be_q, be_d;

  logic slot_free;
  logic accept;
  logic timeout;

  // Handshake: the output slot is free if empty or draining on this edge.
  always_comb begin
    slot_free = !valid_q || out_ready;
    if (state_q == StHalf) begin
      in_ready = slot_free;
    end else begin
      // A lone last byte produces a word immediately, so it needs the slot.
      in_ready = in_last ? slot_free : 1'b1;
    end
    accept  = in_valid && in_ready;
    timeout = (FLUSH_TIMEOUT != 0) && (cnt_q == CntMax) && slot_free;
  end

  // Next-state: pack bytes, flush partials, manage the output slot.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    valid_d = valid_q && !out_ready;
    data_d  = data_q;
    be_d    = be_q;

    case (state_q)
      StEmpty: begin
        if (accept) begin
          if (in_last) begin
            valid_d = 1'b1;
            data_d  = {8'h00, in_byte};
            be_d    = 2'b01;
          end else begin
            hold_d  = in_byte;
            cnt_d   = '0;
            state_d = StHalf;
          end
        end
      end
      StHalf: begin
        // An arriving byte takes priority over a due timeout flush.
        if (accept) begin
          valid_d = 1'b1;
          data_d  = {in_byte, hold_q};
          be_d    = 2'b11;
          cnt_d   = '0;
          state_d = StEmpty;
        end else if (timeout) begin
          valid_d = 1'b1;
          data_d  = {8'h00, hold_q};
          be_d    = 2'b01;
          cnt_d   = '0;
          state_d = StEmpty;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StEmpty;
      end
    endcase
  end

  // State and output registers; reset discards held byte and pending word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StEmpty;
      hold_q  <= 8'h00;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= 16'h0000;
      be_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      be_q    <= be_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_d       = data_q;
  assign out_byteena = be_q;

endmodule

// File: doc/byte_lane_packer.md
Name: byte_lane_packer

Overview:
- Write-side front end for the 16-bit byte-enabled storage registers (clk / resetn / d / byteena / q).
- Accepts a byte stream on a valid/ready handshake and packs it into 16-bit words with matching 2-bit byte enables.
- Lane 0 is d[7:0] and carries the first byte; lane 1 is d[15:8].
- Partial words are flushed on end-of-packet or after an idle timeout, so the downstream register updates only the lanes actually written.

Parameters:
- FLUSH_TIMEOUT, default 8: idle cycles a lone lane-0 byte waits before a partial flush. 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream byte valid.
- in_ready  output  1  packer can accept a byte this cycle.
- in_byte  input  8  byte data.
- in_last  input  1  byte is the last of its packet; forces a flush.
- out_valid  output  1  word valid toward the byte-enabled register.
- out_ready  input  1  downstream accepts the word this cycle.
- out_d  output  16  packed word (drives d).
- out_byteena  output  2  lane enables (drives byteena); bit0 = d[7:0], bit1 = d[15:8].

Behaviour:
- Accept: a byte transfers on a rising edge where in_valid && in_ready. A word transfers on a rising edge where out_valid && out_ready.
- Reset (async, resetn=0): state=EMPTY, hold register=0, idle counter=0, out_valid=0, out_d=16'h0000, out_byteena=2'b00. Reset mid-packet discards any held byte and any pending output word. Outputs leave reset at these values with no glitch word.
- Output slot: a single registered word. slot_free = !out_valid || out_ready.
- While out_valid && !out_ready, out_d and out_byteena are held stable.
- State EMPTY:
  - in_ready=1.
  - Accepted byte with in_last=0: store in hold register, go to HALF, counter=0.
  - Accepted byte with in_last=1 requires slot_free, so in EMPTY in_ready = slot_free when in_last=1. It loads out_d={8'h00,in_byte}, out_byteena=2'b01, out_valid=1, and stays EMPTY.
- State HALF:
  - in_ready = slot_free.
  - Accepted byte (any in_last): out_d={in_byte,hold}, out_byteena=2'b11, out_valid=1, go to EMPTY.
  - No accept: counter increments, saturating at FLUSH_TIMEOUT.
  - Timeout: if FLUSH_TIMEOUT>0 and counter==FLUSH_TIMEOUT and slot_free, then out_d={8'h00,hold}, out_byteena=2'b01, out_valid=1, go to EMPTY.
  - If the slot is busy at timeout, the flush waits in HALF with the counter saturated.
- Simultaneous events:
  - Byte accept and timeout on the same edge: the byte wins, producing a full word with byteena 2'b11 and no partial flush.
  - Word drain and new word load on the same edge: the new word replaces the old; out_valid stays 1.
- Latency:
  - Lane-1 byte accepted at edge N: the word is valid after edge N.
  - Lone byte accepted at edge N with the slot free: the partial word is valid after edge N+FLUSH_TIMEOUT+1.
- No byte is ever dropped or duplicated.
- out_byteena is never 2'b10 and never 2'b00 while out_valid=1.

Test Plan:
- Full word: bytes 8'h67 then 8'h45, out_ready=1 → one word, out_d=16'h4567, out_byteena=2'b11, valid the cycle after the second accept.
- Last flush: single byte 8'h37 with in_last=1 in EMPTY → out_d=16'h0037, out_byteena=2'b01; state stays EMPTY.
- Timeout: FLUSH_TIMEOUT=4, byte 8'hA5 at edge 0 then idle → out_valid rises after edge 5 with out_d=16'h00A5, out_byteena=2'b01. Repeat with FLUSH_TIMEOUT=0: no flush after 20 idle cycles.
- Backpressure: out_ready=0 with word 16'h4567 pending; send 8'h11, 8'h22 → 8'h11 held, in_ready=0 on the second byte. out_d holds 16'h4567 until out_ready=1, then 16'h2211 with byteena 2'b11 follows.
- Race: FLUSH_TIMEOUT=2; the lane-1 byte 8'h99 arrives on the edge where the counter reaches 2 with hold=8'h88 → single word 16'h9988, byteena 2'b11, no 2'b01 word.
- Reset mid-operation: hold 8'h67 in HALF, pulse resetn low asynchronously between edges → out_valid=0, out_d=16'h0000, out_byteena=2'b00 immediately. After release, bytes 8'h45, 8'h23 give 16'h2345 (the stale 8'h67 is discarded).
